// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: execution-controller state encoding and
// the default sequential PC increment.
package mips_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int PC_INCR_DEF = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump beats branch beats the sequential increment.
module pc_next_sel #(
    parameter int PC_WIDTH = 32,
    parameter int PC_INCR  = 4
) (
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_next
);

    // Sum is truncated to PC_WIDTH so the sequential path wraps around.
    always_comb begin
        if (jump)
            pc_next = jump_target;
        else if (branch_taken)
            pc_next = branch_target;
        else
            pc_next = pc + PC_WIDTH'(PC_INCR);
    end

endmodule

// File: rtl/pc_exec_ctrl.sv
// IF-stage execution controller: run/step/pause sequencing, HALT drain and DONE.
// Optional saturating enabled-cycle counter under PC_EXEC_CYCLE_COUNT_EN.
module pc_exec_ctrl
    import mips_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int PC_INCR      = PC_INCR_DEF,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_step,
    input  logic                i_halt_req,
    input  logic                i_halt_instr,
    input  logic                i_stall,
    input  logic                i_jump,
    input  logic [PC_WIDTH-1:0] i_jump_target,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic [PC_WIDTH-1:0] i_pc,
    output logic                o_enable,
    output logic                o_pc_write,
    output logic [PC_WIDTH-1:0] o_pc_next,
    output logic [STATE_W-1:0]  o_state,
    output logic                o_done,
    output logic [31:0]         o_cycle_count
);

    logic [STATE_W-1:0] state, state_nx;
    logic [3:0]         drain, drain_nx;

    assign o_state    = state;
    assign o_enable   = (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
    assign o_done     = (state == ST_DONE);
    // HALT in the fetch slot freezes the PC on the HALT address.
    assign o_pc_write = ((state == ST_RUN) || (state == ST_STEP)) && !i_stall && !i_halt_instr;

    always_comb begin
        state_nx = state;
        drain_nx = drain;
        case (state)
            ST_IDLE: begin
                if (i_run)
                    state_nx = ST_RUN;
                else if (i_step)
                    state_nx = ST_STEP;
            end
            ST_RUN: begin
                if (i_halt_instr) begin
                    state_nx = ST_DRAIN;
                    drain_nx = 4'(DRAIN_CYCLES);
                end else if (i_halt_req) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (i_halt_instr) begin
                    state_nx = ST_DRAIN;
                    drain_nx = 4'(DRAIN_CYCLES);
                end else if (!i_stall) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                drain_nx = drain - 4'd1;
                if (drain == 4'd1)
                    state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            drain <= 4'd0;
        end else begin
            state <= state_nx;
            drain <= drain_nx;
        end
    end

`ifdef PC_EXEC_CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            cycle_count <= 32'd0;
        else if (o_enable && (cycle_count != 32'hFFFF_FFFF))
            cycle_count <= cycle_count + 32'd1;
    end

    assign o_cycle_count = cycle_count;
`else
    assign o_cycle_count = 32'd0;
`endif

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH),
        .PC_INCR  (PC_INCR)
    ) u_pc_next_sel (
        .jump          (i_jump),
        .jump_target   (i_jump_target),
        .branch_taken  (i_branch_taken),
        .branch_target (i_branch_target),
        .pc            (i_pc),
        .pc_next       (o_pc_next)
    );

endmodule

// File: tb/tb_pc_exec_ctrl.sv
// Directed and random bench for pc_exec_ctrl against a behavioural model of
// the run/step/pause/drain rules.
module tb_pc_exec_ctrl;

    localparam int DC = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_run = 1'b0, i_step = 1'b0, i_halt_req = 1'b0, i_halt_instr = 1'b0;
    logic        i_stall = 1'b0, i_jump = 1'b0, i_branch_taken = 1'b0;
    logic [31:0] i_jump_target = 32'd0, i_branch_target = 32'd0, i_pc = 32'd0;
    logic        o_enable, o_pc_write, o_done;
    logic [31:0] o_pc_next, o_cycle_count;
    logic [2:0]  o_state;

    int compared = 0;
    int mismatched = 0;

    // Model: mode 0 idle, 1 run, 2 step, 3 drain, 4 done.
    int          m_mode;
    int          m_left;
    longint      m_cnt;

    pc_exec_ctrl #(.PC_WIDTH(32), .PC_INCR(4), .DRAIN_CYCLES(DC)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
        .i_halt_req(i_halt_req), .i_halt_instr(i_halt_instr), .i_stall(i_stall),
        .i_jump(i_jump), .i_jump_target(i_jump_target),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_pc(i_pc), .o_enable(o_enable), .o_pc_write(o_pc_write),
        .o_pc_next(o_pc_next), .o_state(o_state), .o_done(o_done),
        .o_cycle_count(o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_cnt  = 0;
    endtask

    task automatic check_all();
        longint seq;
        logic [31:0] exp_next, exp_cnt;
        bit running;
        seq = (longint'(i_pc) + 4) % 64'h1_0000_0000;
        exp_next = i_jump ? i_jump_target : (i_branch_taken ? i_branch_target : 32'(seq));
        running = (m_mode == 1) || (m_mode == 2) || (m_mode == 3);
`ifdef PC_EXEC_CYCLE_COUNT_EN
        exp_cnt = 32'(m_cnt);
`else
        exp_cnt = 32'd0;
`endif
        chk("state",   32'(o_state), 32'(m_mode));
        chk("enable",  32'(o_enable), 32'(running));
        chk("pc_write", 32'(o_pc_write),
            32'(((m_mode == 1) || (m_mode == 2)) && !i_stall && !i_halt_instr));
        chk("pc_next", o_pc_next, exp_next);
        chk("done",    32'(o_done), 32'(m_mode == 4));
        chk("count",   o_cycle_count, exp_cnt);
    endtask

    task automatic model_edge();
        bit running;
        if (!i_reset) begin
            model_reset();
            return;
        end
        running = (m_mode >= 1) && (m_mode <= 3);
        if (running && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_mode == 0) begin
            if (i_run) m_mode = 1;
            else if (i_step) m_mode = 2;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (i_halt_instr) begin
                m_mode = 3;
                m_left = DC;
            end else if (m_mode == 1 && i_halt_req) m_mode = 0;
            else if (m_mode == 2 && !i_stall) m_mode = 0;
        end else if (m_mode == 3) begin
            m_left--;
            if (m_left == 0) m_mode = 4;
        end
    endtask

    // Inputs are set just after a falling edge; check, then advance one clock.
    task automatic tick();
        #1 check_all();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        tick();
        tick();
        chk("reset_state", 32'(o_state), 32'd0);

        // Single step with two stalled cycles.
        i_pc = 32'd100;
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
        i_stall = 1'b1;
        tick();
        tick();
        i_stall = 1'b0;
        #1;
        chk("step_write", 32'(o_pc_write), 32'd1);
        chk("step_next", o_pc_next, 32'd104);
        tick();
        chk("step_idle", 32'(o_state), 32'd0);
        tick();

        // Next-PC priority while running.
        i_run = 1'b1;
        tick();
        i_jump = 1'b1; i_jump_target = 32'h400;
        i_branch_taken = 1'b1; i_branch_target = 32'h200;
        #1 chk("prio_jump", o_pc_next, 32'h400);
        tick();
        i_jump = 1'b0;
        #1 chk("prio_branch", o_pc_next, 32'h200);
        tick();
        i_branch_taken = 1'b0;
        i_pc = 32'hFFFF_FFFC;
        #1 chk("seq_wrap", o_pc_next, 32'd0);
        tick();

        // Pause and resume.
        i_run = 1'b0;
        repeat (2) tick();
        i_halt_req = 1'b1;
        tick();
        i_halt_req = 1'b0;
        #1 chk("pause_en", 32'(o_enable), 32'd0);
        tick();
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        #1 chk("resume", 32'(o_state), 32'd1);

        // HALT drain into DONE; later commands ignored.
        i_halt_instr = 1'b1;
        #1 chk("halt_nowrite", 32'(o_pc_write), 32'd0);
        tick();
        i_halt_instr = 1'b0;
        repeat (DC) tick();
        #1 chk("done_flag", 32'(o_done), 32'd1);
        i_run = 1'b1;
        i_step = 1'b1;
        repeat (2) tick();
        i_run = 1'b0;
        i_step = 1'b0;
        chk("done_stuck", 32'(o_state), 32'd4);

        // Async reset in the middle of a drain.
        i_reset = 1'b0;
        model_reset();
        tick();
        i_reset = 1'b1;
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        i_halt_instr = 1'b1;
        tick();
        i_halt_instr = 1'b0;
        tick();
        tick();
        #2 i_reset = 1'b0;
        #1;
        chk("areset_state", 32'(o_state), 32'd0);
        chk("areset_done", 32'(o_done), 32'd0);
        chk("areset_cnt", o_cycle_count, 32'd0);
        chk("areset_en", 32'(o_enable), 32'd0);
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();

        // Random commands against the model.
        for (int n = 0; n < 600; n++) begin
            i_reset         = ($urandom_range(0, 39) != 0);
            i_run           = ($urandom_range(0, 3) == 0);
            i_step          = ($urandom_range(0, 3) == 0);
            i_halt_req      = ($urandom_range(0, 5) == 0);
            i_halt_instr    = ($urandom_range(0, 11) == 0);
            i_stall         = ($urandom_range(0, 2) == 0);
            i_jump          = ($urandom_range(0, 3) == 0);
            i_branch_taken  = ($urandom_range(0, 3) == 0);
            i_jump_target   = $urandom;
            i_branch_target = $urandom;
            i_pc            = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            if (!i_reset) model_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
